// File: rtl/gpio_pkg.sv
// Package for the GPIO port control bank.
// Holds the register address map, the default bank width and the
// arm-counter length used to suppress edges while the synchronizer fills.
package gpio_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  localparam int unsigned ADDR_OUT      = 0;
  localparam int unsigned ADDR_DIR      = 1;
  localparam int unsigned ADDR_PU       = 2;
  localparam int unsigned ADDR_PD       = 3;
  localparam int unsigned ADDR_IN       = 4;
  localparam int unsigned ADDR_RISE_EN  = 5;
  localparam int unsigned ADDR_FALL_EN  = 6;
  localparam int unsigned ADDR_IRQ_STAT = 7;

  // Cycles after reset before edges are allowed through.
  localparam int unsigned ARM_CYCLES = 3;
  localparam int unsigned ARM_W      = $clog2(ARM_CYCLES + 1);

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-bank input synchronizer and edge detector.
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   i_pad_y     : raw pad receiver outputs (asynchronous to clk)
//   o_in_sync   : pad levels after the 2-flop synchronizer
//   o_rise      : per-pin rising edge, one cycle wide, masked until armed
//   o_fall      : per-pin falling edge, one cycle wide, masked until armed
module gpio_sync_edge
  import gpio_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_pad_y,
  output logic [WIDTH-1:0] o_in_sync,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;
  logic [ARM_W-1:0] r_arm_cnt;
  logic             w_armed;

  assign w_armed = (r_arm_cnt == ARM_W'(ARM_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_prev    <= '0;
      r_arm_cnt <= '0;
    end else begin
      r_sync1 <= i_pad_y;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (!w_armed) begin
        r_arm_cnt <= r_arm_cnt + ARM_W'(1);
      end
    end
  end

  assign o_in_sync = r_sync2;
  // A pin high through reset looks like a rise while the chain fills;
  // the arm counter hides that transient.
  assign o_rise    = w_armed ? (r_sync2 & ~r_prev) : '0;
  assign o_fall    = w_armed ? (~r_sync2 & r_prev) : '0;

endmodule

// File: rtl/gpio_port_ctrl.sv
// Register-mapped GPIO control bank for WIDTH pads.
// Ports:
//   clk, rst        : system clock, synchronous active-high reset
//   wr_en, rd_en    : one-cycle register write / read strobes
//   addr, wdata     : register address and write data
//   rdata, rd_valid : registered read data and its one-cycle valid pulse
//   pad_a/oe/pu/pd  : pad drive data, output enable, pull-up, pull-down
//   pad_y           : pad receiver outputs (asynchronous)
//   irq             : registered OR of the interrupt status bits
module gpio_port_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             rd_valid,
  output logic [WIDTH-1:0] pad_a,
  output logic [WIDTH-1:0] pad_oe,
  output logic [WIDTH-1:0] pad_pu,
  output logic [WIDTH-1:0] pad_pd,
  input  logic [WIDTH-1:0] pad_y,
  output logic             irq
);

  localparam logic [AW-1:0] A_OUT      = AW'(ADDR_OUT);
  localparam logic [AW-1:0] A_DIR      = AW'(ADDR_DIR);
  localparam logic [AW-1:0] A_PU       = AW'(ADDR_PU);
  localparam logic [AW-1:0] A_PD       = AW'(ADDR_PD);
  localparam logic [AW-1:0] A_IN       = AW'(ADDR_IN);
  localparam logic [AW-1:0] A_RISE_EN  = AW'(ADDR_RISE_EN);
  localparam logic [AW-1:0] A_FALL_EN  = AW'(ADDR_FALL_EN);
  localparam logic [AW-1:0] A_IRQ_STAT = AW'(ADDR_IRQ_STAT);

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_pu;
  logic [WIDTH-1:0] r_pd;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_irq_stat;
  logic [WIDTH-1:0] r_rdata;
  logic             r_rd_valid;
  logic             r_irq;

  logic [WIDTH-1:0] w_in;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_rd_mux;
  logic [WIDTH-1:0] w_w1c_mask;
  logic [WIDTH-1:0] w_irq_stat_next;

  gpio_sync_edge #(
    .WIDTH (WIDTH)
  ) u_sync_edge (
    .clk       (clk),
    .rst       (rst),
    .i_pad_y   (pad_y),
    .o_in_sync (w_in),
    .o_rise    (w_rise),
    .o_fall    (w_fall)
  );

  // Register write path; IN is read-only and IRQ_STAT is handled below.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out     <= '0;
      r_dir     <= '0;
      r_pu      <= '0;
      r_pd      <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
    end else if (wr_en) begin
      case (addr)
        A_OUT:     r_out     <= wdata;
        A_DIR:     r_dir     <= wdata;
        A_PU:      r_pu      <= wdata;
        A_PD:      r_pd      <= wdata;
        A_RISE_EN: r_rise_en <= wdata;
        A_FALL_EN: r_fall_en <= wdata;
        default:   ;
      endcase
    end
  end

  // Write-one-to-clear, with a fresh edge taking precedence over the clear.
  assign w_w1c_mask      = (wr_en && (addr == A_IRQ_STAT)) ? wdata : '0;
  assign w_irq_stat_next = (r_irq_stat & ~w_w1c_mask)
                         | (w_rise & r_rise_en)
                         | (w_fall & r_fall_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_stat <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_irq_stat <= w_irq_stat_next;
      r_irq      <= |r_irq_stat;
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (addr)
      A_OUT:      w_rd_mux = r_out;
      A_DIR:      w_rd_mux = r_dir;
      A_PU:       w_rd_mux = r_pu;
      A_PD:       w_rd_mux = r_pd;
      A_IN:       w_rd_mux = w_in;
      A_RISE_EN:  w_rd_mux = r_rise_en;
      A_FALL_EN:  w_rd_mux = r_fall_en;
      A_IRQ_STAT: w_rd_mux = r_irq_stat;
      default:    w_rd_mux = '0;
    endcase
  end

  // Read data samples pre-write register values, so a same-address
  // write in the same cycle is not visible until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rdata <= w_rd_mux;
      end
    end
  end

  assign rdata    = r_rdata;
  assign rd_valid = r_rd_valid;
  assign irq      = r_irq;

  assign pad_a  = r_out;
  assign pad_oe = r_dir;
  assign pad_pu = r_pu;
  // Pull-up wins when both pulls are requested.
  assign pad_pd = r_pd & ~r_pu;

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Directed testbench for gpio_port_ctrl with a simple pad model and an
// external driver on pins 4..7.
module tb_gpio_port_ctrl;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       rd_valid;
  logic [7:0] pad_a;
  logic [7:0] pad_oe;
  logic [7:0] pad_pu;
  logic [7:0] pad_pd;
  logic [7:0] pad_y;
  logic       irq;

  logic [7:0] ext_en;
  logic [7:0] ext_val;

  int checks   = 0;
  int failures = 0;

  gpio_port_ctrl #(
    .WIDTH (8),
    .AW    (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rd_valid (rd_valid),
    .pad_a    (pad_a),
    .pad_oe   (pad_oe),
    .pad_pu   (pad_pu),
    .pad_pd   (pad_pd),
    .pad_y    (pad_y),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pad model: own driver first, then external driver, then pull-up;
  // pull-down and floating pins read 0.
  assign pad_y = (pad_oe & pad_a)
               | (~pad_oe & ext_en & ext_val)
               | (~pad_oe & ~ext_en & pad_pu);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
    addr  = a;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk({tag, "_valid"}, {7'b0, rd_valid}, 8'h01);
    chk(tag, rdata, exp);
    tick();
    chk({tag, "_valid_drop"}, {7'b0, rd_valid}, 8'h00);
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    addr    = '0;
    wdata   = '0;
    ext_en  = '0;
    ext_val = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_rd_valid", {7'b0, rd_valid}, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_pad_oe", pad_oe, 8'h00);
    chk("rst_pad_pu", pad_pu, 8'h00);
    chk("rst_pad_pd", pad_pd, 8'h00);
    chk("rst_pad_a", pad_a, 8'h00);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      rd_chk("rst_read", 3'(i), 8'h00);
    end

    // Output drive and loopback
    wr(3'd1, 8'h0F);
    chk("dir_pad_oe", pad_oe, 8'h0F);
    wr(3'd0, 8'h05);
    chk("out_pad_a", pad_a, 8'h05);
    repeat (3) tick();
    rd_chk("loopback_in", 3'd4, 8'h05);

    // Same-cycle read and write of OUT returns the old value
    addr  = 3'd0;
    wdata = 8'hAA;
    wr_en = 1'b1;
    rd_en = 1'b1;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("rw_same_valid", {7'b0, rd_valid}, 8'h01);
    chk("rw_same_old", rdata, 8'h05);
    chk("rw_same_pad_a", pad_a, 8'hAA);
    tick();
    rd_chk("rw_same_new", 3'd0, 8'hAA);

    // Pull-up beats pull-down; PD readback keeps the written value
    wr(3'd1, 8'h00);
    wr(3'd2, 8'h30);
    wr(3'd3, 8'h30);
    chk("pull_pad_pd", pad_pd, 8'h00);
    chk("pull_pad_pu", pad_pu, 8'h30);
    rd_chk("pd_readback", 3'd3, 8'h30);
    wr(3'd4, 8'hFF);
    repeat (3) tick();
    rd_chk("pull_in", 3'd4, 8'h30);
    wr(3'd2, 8'h00);
    wr(3'd3, 8'h00);

    // Rising edge on pin 4
    ext_en  = 8'hF0;
    ext_val = 8'h00;
    wr(3'd5, 8'h10);
    repeat (4) tick();
    chk("pre_rise_irq", {7'b0, irq}, 8'h00);
    ext_val = 8'h10;
    repeat (3) tick();
    chk("rise_irq_e3", {7'b0, irq}, 8'h00);
    tick();
    chk("rise_irq_e4", {7'b0, irq}, 8'h01);
    rd_chk("rise_stat", 3'd7, 8'h10);
    wr(3'd7, 8'h10);
    chk("clr_irq_hold", {7'b0, irq}, 8'h01);
    tick();
    chk("clr_irq_low", {7'b0, irq}, 8'h00);
    rd_chk("clr_stat", 3'd7, 8'h00);

    // Falling edge on pin 7 coincident with a clear of bit 7
    wr(3'd6, 8'h80);
    ext_val = 8'h90;
    repeat (4) tick();
    rd_chk("fall_pre_stat", 3'd7, 8'h00);
    ext_val = 8'h10;
    tick();
    tick();
    wr(3'd7, 8'h80);
    tick();
    chk("fall_irq", {7'b0, irq}, 8'h01);
    rd_chk("fall_vs_clr_stat", 3'd7, 8'h80);
    wr(3'd7, 8'h80);
    tick();
    chk("fall_clr_irq", {7'b0, irq}, 8'h00);

    // Pin 6 held high through reset must not fire after reset
    ext_val = 8'h50;
    repeat (4) tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    wr(3'd5, 8'h40);
    repeat (5) tick();
    chk("arm_irq", {7'b0, irq}, 8'h00);
    rd_chk("arm_stat", 3'd7, 8'h00);
    rd_chk("arm_in", 3'd4, 8'h50);
    rd_chk("arm_rise_en", 3'd5, 8'h40);

    // Reset during a read suppresses the valid pulse
    ext_en = 8'h00;
    addr   = 3'd5;
    rd_en  = 1'b1;
    rst    = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("rst_rd_valid_0", {7'b0, rd_valid}, 8'h00);
    chk("rst_rd_rdata", rdata, 8'h00);
    tick();
    chk("rst_rd_valid_1", {7'b0, rd_valid}, 8'h00);
    rst = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 8; i++) begin
      rd_chk("post_rst_read", 3'(i), 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_port_ctrl.md
Name: gpio_port_ctrl

Overview:
- Register-mapped control bank for WIDTH GPIO_PAD instances, one bank per SPI expander port.
- Sits between the SPI register decoder upstream and the pad cells downstream.
- Drives each pad's a/oe/pu/pd from registers and samples each pad's y through a 2-flop synchronizer.
- Detects rising/falling edges per pin and raises a level interrupt.

Parameters:
- WIDTH, 8: number of pins in the bank; also the data-bus width.
- AW, 3: register address width; 8 registers are mapped.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  register write strobe, one cycle per write.
- rd_en  in  1  register read strobe, one cycle per read.
- addr  in  AW  register address.
- wdata  in  WIDTH  write data.
- rdata  out  WIDTH  read data.
- rd_valid  out  1  one-cycle pulse; rdata is valid in that cycle.
- pad_a  out  WIDTH  output data, to pad a.
- pad_oe  out  WIDTH  output enable, to pad oe (1 = drive).
- pad_pu  out  WIDTH  pull-up enable, to pad pu.
- pad_pd  out  WIDTH  pull-down enable, to pad pd.
- pad_y  in  WIDTH  pad receiver output; asynchronous to clk.
- irq  out  1  level interrupt, equal to OR of IRQ_STAT.

Behaviour:
- Register map: 0 OUT rw; 1 DIR rw; 2 PU rw; 3 PD rw; 4 IN ro; 5 RISE_EN rw; 6 FALL_EN rw; 7 IRQ_STAT rw1c.
- Reset, synchronous while rst=1: all registers 0; rdata=0, rd_valid=0, irq=0; sync flops, previous-sample register and arm counter all 0.
- Reset result at the pads: every pad is an input, no pulls, a=0.
- rst asserted mid-transaction: a read in flight produces no rd_valid pulse.
- Write path: on wr_en the addressed register updates at the clock edge; pad_* outputs change the following cycle (1-cycle latency).
- Writes to IN are ignored.
- Outputs: pad_a=OUT, pad_oe=DIR, pad_pu=PU, pad_pd=PD & ~PU.
  - PU wins on conflict; PD register readback still returns the written value.
- Read path: on rd_en, rdata is loaded with the addressed register value (pre-write value if wr_en hits the same address in the same cycle).
  - rd_valid=1 for exactly the next cycle; rdata then holds until the next read.
- Simultaneous wr_en and rd_en: both are performed.
- Input path: pad_y passes through sync1 then sync2.
  - IN = sync2, so IN reflects a pad change 2 clocks after it is stable.
  - A read of IN returns it one further cycle later.
- Edge detect: prev <= sync2 every cycle.
  - rise = sync2 & ~prev; fall = ~sync2 & prev.
- Arming: a 2-bit arm counter counts 3 cycles after reset. rise/fall are masked until the counter is saturated, so no spurious edge fires while the sync chain fills.
- IRQ_STAT update per bit: next = (cur & ~w1c_mask) | (rise & RISE_EN) | (fall & FALL_EN).
  - w1c_mask = wdata when a write hits addr 7, else 0.
  - A new edge in the same cycle as a clear wins: the bit stays 1.
- Enable changes: clearing RISE_EN/FALL_EN does not clear already-latched status bits.
- irq is registered (one cycle after IRQ_STAT changes), then stays asserted until all bits are cleared.
- Unmapped addresses (none when AW=3): reads return 0, writes are ignored.
- Pins with DIR=1 still sample y and generate edges, giving loopback of the driven value.

Decomposition:
- Package gpio_pkg:
  - register address constants (ADDR_OUT … ADDR_IRQ_STAT);
  - default WIDTH;
  - ARM_CYCLES=3.
- One sub-module: gpio_sync_edge (per-bank 2-flop synchronizer, prev register, arm counter; outputs in_sync, rise, fall).
- Register file, read mux and IRQ logic stay in the top module.

Test Plan (WIDTH=8, pads are GPIO_PAD models; external driver on pins 4–7):
- Reset, then read every address → all return 0x00, rd_valid pulses once per read; pad_oe=0x00, pad_pu=0x00, irq=0.
- Write DIR=0x0F, then OUT=0x05 → pad_oe=0x0F the cycle after the DIR write, pad_a=0x05 the cycle after the OUT write. Pad pins 0 and 2 read 1, pins 1 and 3 read 0. Read IN 3+ cycles later → low nibble = 0x5.
- PU=0x30, PD=0x30, DIR=0, pins undriven → pad_pd=0x00; PD readback=0x30; IN bits 5:4 = 1.
- RISE_EN=0x10, drive pin 4 0→1 → IRQ_STAT=0x10 at edge+3 cycles, irq=1 one cycle later. Write 0x10 to addr 7 → irq=0 two cycles after the write.
- FALL_EN=0x80, clear bit 7 in the same cycle that its falling edge reaches the detector → IRQ_STAT bit 7 remains 1.
- Hold pin 6 high through reset with RISE_EN=0x40 enabled after reset → no IRQ_STAT bit set. Then assert rst mid-read → rd_valid stays 0 and all registers read 0x00 afterwards.
